chacha_stream_xor: RTL and testbench

- Downstream consumer of the chacha block core. It programs the 32-bit block counter, waits for blk_ready, and burst-reads the 64-byte keystream block into a local buffer.
- It then XORs that buffer byte-by-byte with an incoming plaintext/ciphertext stream over valid/ready handshakes.
- After 64 bytes it advances the counter and fetches the next block. The key and nonce are loaded elsewhere; this block touches only the counter and the read path.

---
 rtl/chacha_stream_xor.sv | 118 +++++++++++
 tb/tb_chacha_stream_xor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor: fetches 64-byte chacha keystream blocks from the core and XORs them onto a byte stream
module chacha_stream_xor #(
    parameter int BLK_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ctr_init,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        ctr_wrap,
    output logic        core_wr_ctr,
    output logic        core_rd_blk,
    output logic [7:0]  core_din,
    input  logic        core_blk_ready,
    input  logic [7:0]  core_dout
);
    typedef enum logic [2:0] {IDLE, WR_CTR, WAIT_BLK, LOAD, STREAM} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt, cnt_nx, idx;
    logic [31:0] ctr, ctr_sh;
    logic [7:0]  ks_buf [BLK_BYTES];
    logic        in_fire, out_fire, last_byte, ctr_max;

    assign in_ready    = (state == STREAM) && (!out_valid || out_ready);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign last_byte   = in_fire && (idx == 6'(BLK_BYTES - 1));
    assign ctr_max     = ctr == 32'hFFFF_FFFF;
    assign busy        = state != IDLE;
    assign ctr_sh      = ctr >> {cnt[1:0], 3'b000};
    assign core_wr_ctr = (state == WR_CTR) && (cnt == 6'd0);
    assign core_din    = (state == WR_CTR) ? ctr_sh[7:0] : 8'h00;
    assign core_rd_blk = (state == LOAD) && (cnt == 6'd0);

    // state and per-state cycle counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // next-state: counter write, blk_ready wait (first cycle blind), 64-cycle load, stream until last byte
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                state_nx = start ? WR_CTR : IDLE;
                cnt_nx   = 6'd0;
            end
            WR_CTR: begin
                state_nx = (cnt == 6'd3) ? WAIT_BLK : WR_CTR;
                cnt_nx   = (cnt == 6'd3) ? 6'd0 : cnt + 6'd1;
            end
            WAIT_BLK: begin
                state_nx = (cnt != 6'd0 && core_blk_ready) ? LOAD : WAIT_BLK;
                cnt_nx   = (cnt != 6'd0 && core_blk_ready) ? 6'd0 : 6'd1;
            end
            LOAD: begin
                state_nx = (cnt == 6'(BLK_BYTES - 1)) ? STREAM : LOAD;
                cnt_nx   = cnt + 6'd1;
            end
            STREAM: begin
                state_nx = !last_byte ? STREAM : (stop || ctr_max) ? IDLE : WR_CTR;
                cnt_nx   = 6'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 6'd0;
            end
        endcase
    end

    // counter, wrap flag, stream index and the registered output byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr       <= 32'd0;
            ctr_wrap  <= 1'b0;
            idx       <= 6'd0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            if (state == IDLE && start) begin
                ctr      <= ctr_init;
                ctr_wrap <= 1'b0;
            end
            if (last_byte && !stop) begin
                ctr      <= ctr_max ? ctr : ctr + 32'd1;
                ctr_wrap <= ctr_wrap || ctr_max;
            end
            idx <= (state == LOAD) ? 6'd0 : in_fire ? idx + 6'd1 : idx;
            if (in_fire) begin
                out_data  <= in_data ^ ks_buf[idx];
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    // keystream buffer: byte k is captured on load cycle k
    always_ff @(posedge clk) begin
        if (state == LOAD)
            ks_buf[cnt] <= core_dout;
    end
endmodule

// File: tb/tb_chacha_stream_xor.sv
// tb_chacha_stream_xor: directed bench with a core model and a queue-based stream scoreboard
module tb_chacha_stream_xor;
    logic        clk = 1'b0;
    logic        rst_n, start, stop, in_valid, out_ready;
    logic [31:0] ctr_init;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, busy, ctr_wrap, core_wr_ctr, core_rd_blk;
    logic [7:0]  out_data, core_din;
    logic        core_blk_ready = 1'b0;
    logic [7:0]  core_dout = 8'h00;

    int          checks = 0, errors = 0, n_out = 0;
    logic [7:0]  ks_mask = 8'hA5;
    logic [7:0]  ks_model [64];
    int          lk = 63, rdy_cnt = 0, pos = 0;
    logic [7:0]  exp_q [$];
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_data = 8'h00;

    chacha_stream_xor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ctr_init(ctr_init),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .ctr_wrap(ctr_wrap), .core_wr_ctr(core_wr_ctr), .core_rd_blk(core_rd_blk),
        .core_din(core_din), .core_blk_ready(core_blk_ready), .core_dout(core_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ev(input int sel);
        return sel == 0 ? core_rd_blk : sel == 1 ? in_ready : sel == 2 ? core_wr_ctr : !busy;
    endfunction

    task automatic wait_for(input string name, input int sel, input int lim);
        int n = 0;
        while (!ev(sel) && n < lim) begin
            tick;
            n++;
        end
        checks++;
        if (!ev(sel)) begin
            errors++;
            $display("FAIL %s: no event after %0d cycles, event required", name, n);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ctr_wrap"}, ctr_wrap, 0);
        chk({tag, "_wr_ctr"}, core_wr_ctr, 0);
        chk({tag, "_rd_blk"}, core_rd_blk, 0);
        chk({tag, "_din"}, core_din, 0);
    endtask

    // core model: blk_ready some cycles after a counter write; data k^mask from the rd_blk cycle on
    always @(negedge clk) begin
        if (core_wr_ctr) begin
            rdy_cnt = 6;
            core_blk_ready = 1'b0;
        end else if (core_rd_blk) begin
            core_blk_ready = 1'b0;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) core_blk_ready = 1'b1;
        end
        if (core_rd_blk || lk < 63) begin
            lk = core_rd_blk ? 0 : lk + 1;
            core_dout = 8'(lk) ^ ks_mask;
            ks_model[lk] = core_dout;
        end
    end

    // scoreboard: every accepted input byte must come out once, in order, XORed with its keystream byte
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pos = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
            end
            if (!busy) chk("in_ready_idle", in_ready, 0);
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra: got %h expected no byte", out_data);
                end else begin
                    chk("stream_data", out_data, exp_q.pop_front());
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data ^ ks_model[pos]);
                pos = (pos + 1) % 64;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb, wr_seen;
        logic [31:0] exp_w;
        rst_n = 0; start = 0; stop = 0; ctr_init = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        repeat (3) tick;
        chk_reset_vals("rst");
        rst_n = 1;
        tick;
        // counter write little-endian, wr_ctr on first cycle only
        ctr_init = 32'h0403_0201;
        start = 1;
        tick;
        start = 0;
        chk("wr_ctr_c0", core_wr_ctr, 1);
        chk("din_c0", core_din, 8'h01);
        chk("busy_run", busy, 1);
        exp_w = 32'h0403_0201;
        for (int i = 1; i < 4; i++) begin
            tick;
            chk("wr_ctr_cn", core_wr_ctr, 0);
            chk("din_cn", core_din, exp_w[8*i +: 8]);
        end
        // block 1: zero plaintext, full throughput
        wait_for("rd_blk1", 0, 50);
        tick;
        chk("rd_blk_pulse", core_rd_blk, 0);
        in_valid = 1;
        in_data = 8'h00;
        wait_for("stream1", 1, 100);
        tick;
        chk("first_valid", out_valid, 1);
        chk("first_byte", out_data, 8'hA5);
        tick;
        chk("byte1", out_data, 8'hA4);
        tick;
        chk("byte2", out_data, 8'hA7);
        // second block: counter advanced by one
        wait_for("wr_ctr2", 2, 200);
        chk("ctr2_b0", core_din, 8'h02);
        ks_mask = 8'h3C;
        tick;
        chk("ctr2_b1", core_din, 8'h02);
        tick;
        chk("ctr2_b2", core_din, 8'h03);
        tick;
        chk("ctr2_b3", core_din, 8'h04);
        wait_for("rd_blk2", 0, 50);
        chk("blk_ready_before_rd", core_blk_ready, 1);
        stop = 1;
        for (int i = 0; i < 1000 && busy; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            in_data = 8'(i * 7 + 3);
            tick;
        end
        chk("blk2_done", busy, 0);
        out_ready = 1;
        tick;
        tick;
        chk("blk2_drained", out_valid, 0);
        chk("blk2_queue", exp_q.size(), 0);
        chk("blk2_count", n_out, 128);
        // counter wrap
        stop = 0;
        ctr_init = 32'hFFFF_FFFF;
        start = 1;
        tick;
        start = 0;
        chk("wrap_wr_ctr", core_wr_ctr, 1);
        chk("wrap_din", core_din, 8'hFF);
        for (int i = 0; i < 400 && busy; i++) begin
            in_data = 8'(i);
            tick;
        end
        chk("wrap_idle", busy, 0);
        chk("wrap_flag", ctr_wrap, 1);
        wr_seen = 0;
        repeat (6) begin
            tick;
            if (core_wr_ctr) wr_seen++;
        end
        chk("wrap_no_wr", wr_seen, 0);
        chk("wrap_queue", exp_q.size(), 0);
        // start with stop held: start wins and clears the wrap flag
        ctr_init = 32'h0000_0010;
        stop = 1;
        start = 1;
        tick;
        start = 0;
        chk("wrap_cleared", ctr_wrap, 0);
        chk("restart_din", core_din, 8'h10);
        chk("restart_busy", busy, 1);
        // reset during load cycle 30
        wait_for("rd_blk3", 0, 50);
        repeat (30) tick;
        rst_n = 0;
        tick;
        chk_reset_vals("midrst");
        rst_n = 1;
        tick;
        // fresh run after reset
        ctr_init = 32'h0A0B_0C0D;
        start = 1;
        tick;
        start = 0;
        chk("fresh_din", core_din, 8'h0D);
        nb = n_out;
        for (int i = 0; i < 400 && busy; i++) begin
            in_data = 8'(i * 13);
            tick;
        end
        chk("fresh_idle", busy, 0);
        tick;
        tick;
        chk("fresh_queue", exp_q.size(), 0);
        chk("fresh_count", n_out - nb, 64);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
